// File: rtl/hls_perf_monitor.sv
// ============================================================================
// Module   : hls_perf_monitor
// Purpose  : Per-channel ap_ctrl_hs performance statistics with a one-cycle
//            register-read port. Optional stall counter: PERF_MON_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hls_perf_monitor #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              freeze,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [NUM_CH-1:0] iter_end,
    input  logic              rd_en,
    input  logic [3:0]        rd_ch,
    input  logic [3:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err
);

    localparam int C_AW   = $clog2(OUT_DEPTH);
    localparam int C_LW   = C_AW + 1;
    localparam int C_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACTIVE    = 2'd1;
    localparam logic [1:0] ST_DONE_HOLD = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] r_ts;

    logic [CNT_W-1:0] w_txn         [NUM_CH];
    logic [CNT_W-1:0] w_last_lat    [NUM_CH];
    logic [CNT_W-1:0] w_min_lat     [NUM_CH];
    logic [CNT_W-1:0] w_max_lat     [NUM_CH];
    logic [CNT_W-1:0] w_last_intv   [NUM_CH];
    logic [CNT_W-1:0] w_last_iters  [NUM_CH];
    logic [CNT_W-1:0] w_total_iters [NUM_CH];
    logic [CNT_W-1:0] w_status      [NUM_CH];
`ifdef PERF_MON_STALL_CNT_EN
    logic [CNT_W-1:0] w_stall       [NUM_CH];
`endif

    // The timestamp ignores clr and freeze so latencies stay wall-clock based.
    always_ff @(posedge clock) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] r_mem [OUT_DEPTH];
        logic [C_AW:0]    r_wp, r_rp;
        logic [CNT_W-1:0] r_txn, r_last_lat, r_min_lat, r_max_lat;
        logic [CNT_W-1:0] r_last_intv, r_last_push;
        logic [CNT_W-1:0] r_cur_iters, r_last_iters, r_total_iters;
        logic             r_has_push, r_ovf, r_unf;

        logic [C_LW-1:0]  w_level;
        logic             w_empty, w_full;
        logic             w_push, w_pop, w_iter;
        logic             w_bypass, w_wr, w_rd, w_lat_ok;
        logic [CNT_W-1:0] w_lat;
        logic [1:0]       w_state;

        assign w_level  = r_wp - r_rp;
        assign w_empty  = (w_level == '0);
        assign w_full   = (w_level == C_LW'(OUT_DEPTH));
        assign w_push   = ~freeze & ap_start[c] & ap_ready[c];
        assign w_pop    = ~freeze & ap_done[c] & ap_continue[c];
        assign w_iter   = ~freeze & iter_end[c];
        assign w_bypass = w_push & w_pop & w_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO then fits.
        assign w_wr     = w_push & ~w_bypass & (~w_full | w_pop);
        assign w_rd     = w_pop & ~w_empty;
        assign w_lat_ok = w_rd | w_bypass;
        assign w_lat    = w_bypass ? '0 : r_ts - r_mem[r_rp[C_AW-1:0]];

        assign w_state = (ap_done[c] & ~ap_continue[c]) ? ST_DONE_HOLD :
                         (~w_empty | ap_start[c])      ? ST_ACTIVE    : ST_IDLE;

        always_ff @(posedge clock) begin
            if (w_wr) r_mem[r_wp[C_AW-1:0]] <= r_ts;
        end

        always_ff @(posedge clock) begin
            if (reset || clr) begin
                r_wp          <= '0;
                r_rp          <= '0;
                r_txn         <= '0;
                r_last_lat    <= '0;
                r_min_lat     <= '1;
                r_max_lat     <= '0;
                r_last_intv   <= '0;
                r_last_push   <= '0;
                r_cur_iters   <= '0;
                r_last_iters  <= '0;
                r_total_iters <= '0;
                r_has_push    <= 1'b0;
                r_ovf         <= 1'b0;
                r_unf         <= 1'b0;
            end else begin
                if (w_wr) r_wp <= r_wp + 1'b1;
                if (w_rd) r_rp <= r_rp + 1'b1;
                if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
                if (w_pop && w_empty && !w_push) r_unf <= 1'b1;

                if (w_push) begin
                    if (r_has_push) r_last_intv <= r_ts - r_last_push;
                    r_last_push <= r_ts;
                    r_has_push  <= 1'b1;
                end

                if (w_pop) begin
                    r_txn        <= sat_inc(r_txn);
                    r_last_iters <= r_cur_iters;
                    r_cur_iters  <= w_iter ? CNT_W'(1) : '0;
                end else if (w_iter) begin
                    r_cur_iters  <= sat_inc(r_cur_iters);
                end
                if (w_iter) r_total_iters <= sat_inc(r_total_iters);

                if (w_lat_ok) begin
                    r_last_lat <= w_lat;
                    if (w_lat < r_min_lat) r_min_lat <= w_lat;
                    if (w_lat > r_max_lat) r_max_lat <= w_lat;
                end
            end
        end

        assign w_txn[c]         = r_txn;
        assign w_last_lat[c]    = r_last_lat;
        assign w_min_lat[c]     = r_min_lat;
        assign w_max_lat[c]     = r_max_lat;
        assign w_last_intv[c]   = r_last_intv;
        assign w_last_iters[c]  = r_last_iters;
        assign w_total_iters[c] = r_total_iters;
        assign w_status[c]      = CNT_W'({w_level, r_unf, r_ovf, w_state});

`ifdef PERF_MON_STALL_CNT_EN
        logic [CNT_W-1:0] r_stall;
        always_ff @(posedge clock) begin
            if (reset || clr)
                r_stall <= '0;
            else if (!freeze && ((ap_start[c] && !ap_ready[c]) || w_state == ST_DONE_HOLD))
                r_stall <= sat_inc(r_stall);
        end
        assign w_stall[c] = r_stall;
`endif
    end

    logic [C_CH_W-1:0] w_idx;
    logic              w_ch_ok;
    logic [CNT_W-1:0]  w_rd_data;
    logic              w_rd_err;

    assign w_idx   = rd_ch[C_CH_W-1:0];
    assign w_ch_ok = ({1'b0, rd_ch} < 5'(NUM_CH));

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (!w_ch_ok) begin
            w_rd_err = 1'b1;
        end else begin
            case (rd_sel)
                4'd0:    w_rd_data = w_txn[w_idx];
                4'd1:    w_rd_data = w_last_lat[w_idx];
                4'd2:    w_rd_data = w_min_lat[w_idx];
                4'd3:    w_rd_data = w_max_lat[w_idx];
                4'd4:    w_rd_data = w_last_intv[w_idx];
                4'd5:    w_rd_data = w_last_iters[w_idx];
                4'd6:    w_rd_data = w_total_iters[w_idx];
                4'd7:    w_rd_data = w_status[w_idx];
`ifdef PERF_MON_STALL_CNT_EN
                4'd8:    w_rd_data = w_stall[w_idx];
`endif
                default: w_rd_err  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? w_rd_data : '0;
            rd_err   <= rd_en & w_rd_err;
        end
    end

endmodule

`default_nettype wire

// File: doc/hls_perf_monitor.md
Name: hls_perf_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only dataflow/loop monitors.
- Observes the ap_ctrl_hs handshakes and loop-iteration strobes of NUM_CH HLS modules.
- Accumulates per-channel performance statistics: transaction count, latency, interval and iteration counts.
- Serves the statistics through a one-cycle register-read port, so they survive into on-board runs where CSV dumping is not available.

Parameters:
- NUM_CH, 4: number of monitored modules (1..16).
- CNT_W, 32: width of timestamp and all statistic counters.
- OUT_DEPTH, 4: per-channel outstanding-start FIFO depth (power of 2, ≥2). Supports pipelined modules with interval < latency.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  synchronous statistics clear.
- freeze  in  1  while 1, no statistic or FIFO updates (finish hold).
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready.
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 when absent).
- iter_end  in  NUM_CH  qualified loop-iteration-complete strobe.
- rd_en  in  1  read request.
- rd_ch  in  4  channel select.
- rd_sel  in  4  field select.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- rd_err  out  1  bad channel or field on this read.

Behaviour:
- Reset: all outputs 0; all counters, FIFOs, flags and the timestamp cleared; min_latency set to all-ones. clr has the same effect except the timestamp keeps running.
- Timestamp ts: free-running CNT_W counter, +1 per cycle, wraps modulo 2^CNT_W. Runs even during freeze.
- Per channel c, events:
  - push = ap_start & ap_ready (start accepted).
  - pop = ap_done & ap_continue (completion accepted).
- FIFO:
  - push writes ts into the channel FIFO.
  - pop reads the head and computes lat = (ts − head) mod 2^CNT_W.
- Simultaneous push/pop with an empty FIFO: bypass, lat = 0, FIFO stays empty.
- Push when full: entry dropped, sticky ovf flag set, txn tracking continues.
- Pop when empty (no bypass): sticky unf flag set, latency statistics not updated, txn_count still increments.
- On valid pop:
  - last_latency = lat
  - min_latency = min(min, lat)
  - max_latency = max(max, lat)
  - txn_count += 1
  - last_iters = cur_iters
  - cur_iters cleared, or set to 1 if iter_end is asserted in the same cycle.
- iter_end pulse: cur_iters += 1 and total_iters += 1.
- On push: last_interval = ts − last_push_ts when a prior push exists (else unchanged); last_push_ts = ts.
- All statistic counters saturate at all-ones; never wrap.
- Per-channel state (readable), priority top-down:
  - DONE_HOLD (2): ap_done=1 & ap_continue=0.
  - ACTIVE (1): FIFO non-empty, or ap_start=1.
  - IDLE (0): otherwise.
- freeze=1: push, pop and iter_end are ignored. Statistics and FIFOs hold. Reads still served.
- Read port: rd_en sampled at cycle N → rd_valid=1 and rd_data at cycle N+1 (registered). rd_valid is a single-cycle pulse per request, back-to-back reads allowed.
- Field map (rd_sel):
  - 0 txn_count
  - 1 last_latency
  - 2 min_latency (all-ones if no txn)
  - 3 max_latency
  - 4 last_interval
  - 5 last_iters
  - 6 total_iters
  - 7 status = {.., fifo_level[log2(OUT_DEPTH):0], unf, ovf, state[1:0]}, zero-extended to CNT_W
  - 8 stall_cnt (optional feature)
  - others: rd_data=0, rd_err=1
- rd_ch ≥ NUM_CH: rd_data=0, rd_err=1.
- Read coinciding with an update: returns the pre-update value.
- reset mid-operation: everything clears next cycle and any in-flight read is dropped (rd_valid=0).

Optional Feature:
- PERF_MON_STALL_CNT_EN defined: per-channel stall_cnt increments each non-frozen cycle where (ap_start=1 & ap_ready=0) or state=DONE_HOLD. Saturating, cleared by reset/clr, read at rd_sel=8.
- Undefined: no stall logic; rd_sel=8 returns 0 with rd_err=1.

Test Plan:
- Single txn on ch0: start/ready at ts=10, done/continue at ts=25, 5 iter_end pulses → txn=1, last=min=max=15, last_iters=5, total_iters=5, state=IDLE.
- Pipelined ch1, OUT_DEPTH=4: accepts at ts 0,3,6, dones at 20,23,26 → last_latency=20, last_interval=3, level returns 0, ovf=0. Fifth outstanding accept with 4 pending → ovf=1, txn continues.
- ch2: ap_done=1, ap_continue=0 for 7 cycles, then continue=1 → state=DONE_HOLD during hold, txn increments once. With PERF_MON_STALL_CNT_EN, stall_cnt=7.
- Bypass and underflow: push+pop same cycle on empty ch3 → last_latency=0, min=0. Lone pop on empty → unf=1, txn+1, latency fields unchanged.
- Saturation/wrap with CNT_W=8: push at ts=250, pop at ts=4 → latency=10. 300 iter_end pulses → total_iters=255.
- Control: freeze=1 during a full txn → all fields unchanged. Read rd_ch=NUM_CH → rd_err=1, rd_data=0. reset at an arbitrary cycle → all reads 0 and min_latency=all-ones next.
